shift_deser: RTL and testbench

Serial-to-parallel receiver sitting directly downstream of the 4-bit shift register. It samples that stage's serial output (MSB first) on a bit strobe and detects a start bit. It assembles `WIDTH`-bit words and delivers them through a 2-entry output buffer with a valid/ready handshake. A sticky overflow flag records words dropped because the buffer was full.

---
 rtl/shift_deser.sv | 146 ++++++++++++++
 tb/tb_shift_deser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: start-bit framing, MSB-first assembly, 2-entry output FIFO.
// Optional per-word even-parity check enabled by defining SHIFT_DESER_PARITY_EN.
module shift_deser #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             clr_ovf,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overflow
`ifdef SHIFT_DESER_PARITY_EN
  ,
  output logic             data_perr
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
`ifdef SHIFT_DESER_PARITY_EN
    ,
    PAR  = 2'd2
`endif
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [WIDTH-1:0] shifted;
  logic             push;
  logic [WIDTH-1:0] push_word;
  logic             push_perr;

  logic [WIDTH-1:0] mem [2];
  logic             perr_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             pop, full, accept, drop;

  assign shifted = {sreg[WIDTH-2:0], serial_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sreg  <= sreg_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sreg_next  = sreg;
    push       = 1'b0;
    push_word  = '0;
    push_perr  = 1'b0;
    if (bit_valid) begin
      unique case (state)
        IDLE: begin
          if (serial_in) begin
            state_next = DATA;
            cnt_next   = '0;
          end
        end
        DATA: begin
          sreg_next = shifted;
          cnt_next  = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_DESER_PARITY_EN
            state_next = PAR;
`else
            state_next = IDLE;
            push       = 1'b1;
            push_word  = shifted;
`endif
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PAR: begin
          state_next = IDLE;
          push       = 1'b1;
          push_word  = sreg;
          push_perr  = (^sreg) ^ serial_in;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // A push into a full buffer survives only if the head is popped on the same edge.
  assign data_valid = (count != 2'd0);
  assign full       = (count == 2'd2);
  assign pop        = data_valid && data_ready;
  assign accept     = push && (!full || pop);
  assign drop       = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      overflow    <= 1'b0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      perr_mem[0] <= 1'b0;
      perr_mem[1] <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr]      <= push_word;
        perr_mem[wr_ptr] <= push_perr;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (clr_ovf)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign data_out = data_valid ? mem[rd_ptr] : '0;
  assign busy     = (state != IDLE);

`ifdef SHIFT_DESER_PARITY_EN
  assign data_perr = data_valid ? perr_mem[rd_ptr] : 1'b0;
`else
  logic unused_perr;
  assign unused_perr = push_perr ^ perr_mem[0] ^ perr_mem[1];
`endif

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios plus randomized frames
// checked against a frame-level queue model of the output buffer.
module tb_shift_deser;
  localparam int unsigned W = 4;
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, bit_valid, serial_in, clr_ovf, data_ready;
  logic [W-1:0] data_out;
  logic         data_valid, busy, overflow;
  logic         perr_obs;

`ifdef SHIFT_DESER_PARITY_EN
  logic data_perr;
  assign perr_obs = data_perr;
`else
  assign perr_obs = 1'b0;
`endif

  shift_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .clr_ovf    (clr_ovf),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overflow   (overflow)
`ifdef SHIFT_DESER_PARITY_EN
    ,
    .data_perr  (data_perr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    logic         p;
  } ent_t;

  ent_t q[$];
  logic m_ovf  = 1'b0;
  logic m_busy = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;   // 0: low, 1: high, 2: random per cycle
  logic clr_req  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("data_valid", 32'(data_valid), 32'(q.size() > 0));
    check("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0].w) : 32'd0);
    check("busy", 32'(busy), 32'(m_busy));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (PAR_EN) check("data_perr", 32'(perr_obs), (q.size() > 0) ? 32'(q[0].p) : 32'd0);
  endtask

  // One clock: drive, advance, update model, compare just after the edge.
  task automatic step(input logic bv, input logic si, input logic start, input logic last,
                      input logic [W-1:0] w, input logic pe);
    logic rdy;
    logic drop;
    rdy        = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
    reset      = 1'b0;
    bit_valid  = bv;
    serial_in  = si;
    data_ready = rdy;
    clr_ovf    = clr_req;
    @(posedge clk);
    drop = 1'b0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (last) begin
      if (q.size() < 2) q.push_back('{w: w, p: pe});
      else drop = 1'b1;
    end
    if (clr_req) m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
    if (start) m_busy = 1'b1;
    if (last) m_busy = 1'b0;
    #1 compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset      = 1'b1;
    bit_valid  = 1'b1;
    serial_in  = 1'b1;
    clr_ovf    = 1'b0;
    data_ready = 1'b1;
    repeat (n) @(posedge clk);
    q.delete();
    m_ovf  = 1'b0;
    m_busy = 1'b0;
    #1 compare_all();
    reset = 1'b0;
  endtask

  // Start bit, W data bits MSB first, then parity when enabled.
  task automatic send_frame(input logic [W-1:0] w, input logic p, input bit gaps, input int last_rdy);
    logic pe;
    int   saved;
    pe = PAR_EN ? ((^w) ^ p) : 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, w, pe);
    for (int i = W - 1; i >= 0; i--) begin
      while (gaps && $urandom_range(0, 2) == 0) idle(1);
      saved = rdy_mode;
      if (i == 0 && !PAR_EN && last_rdy >= 0) rdy_mode = last_rdy;
      step(1'b1, w[i], 1'b0, (i == 0) && !PAR_EN, w, pe);
      rdy_mode = saved;
    end
    if (PAR_EN) begin
      while (gaps && $urandom_range(0, 2) == 0) idle(1);
      saved = rdy_mode;
      if (last_rdy >= 0) rdy_mode = last_rdy;
      step(1'b1, p, 1'b0, 1'b1, w, pe);
      rdy_mode = saved;
    end
  endtask

  initial begin
    reset = 1'b1; bit_valid = 1'b0; serial_in = 1'b0; clr_ovf = 1'b0; data_ready = 1'b0;

    do_reset(3);
    check("reset_busy", 32'(busy), 32'd0);

    // Single frame 0xA with leading zeros, consumer ready
    rdy_mode = 1;
    zeros(2);
    send_frame(4'hA, 1'b0, 1'b0, -1);
    check("first_word", 32'(data_out), 32'hA);
    idle(1);
    check("valid_one_cycle", 32'(data_valid), 32'd0);

    // Back-to-back frames held, then drained on consecutive cycles
    rdy_mode = 0;
    send_frame(4'hA, 1'b0, 1'b0, -1);
    send_frame(4'h5, 1'b0, 1'b0, -1);
    idle(2);
    rdy_mode = 1;
    idle(3);

    // Overflow on a full buffer, then clear
    rdy_mode = 0;
    send_frame(4'hA, 1'b0, 1'b0, -1);
    send_frame(4'h5, 1'b0, 1'b0, -1);
    send_frame(4'h3, 1'b0, 1'b0, -1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head", 32'(data_out), 32'hA);
    clr_req = 1'b1; idle(1); clr_req = 1'b0;
    rdy_mode = 1; idle(3);

    // Same with the consumer popping on the push edge
    rdy_mode = 0;
    send_frame(4'hA, 1'b0, 1'b0, -1);
    send_frame(4'h5, 1'b0, 1'b0, -1);
    send_frame(4'h3, 1'b0, 1'b0, 1);
    check("pop_push_ovf", 32'(overflow), 32'd0);
    check("pop_push_head", 32'(data_out), 32'h5);
    rdy_mode = 1; idle(3);

    // Reset mid-frame, then a clean frame
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    do_reset(1);
    check("midreset_busy", 32'(busy), 32'd0);
    rdy_mode = 0;
    send_frame(4'h3, 1'b0, 1'b0, -1);
    check("after_reset_word", 32'(data_out), 32'h3);
    rdy_mode = 1; idle(2);

    if (PAR_EN) begin
      rdy_mode = 0;
      send_frame(4'hA, 1'b0, 1'b0, -1);
      send_frame(4'hA, 1'b1, 1'b0, -1);
      check("perr_a0", 32'(perr_obs), 32'd0);
      rdy_mode = 1; idle(1);
      check("perr_a1", 32'(perr_obs), 32'd1);
      idle(1);
      send_frame(4'h7, 1'b1, 1'b0, -1);
      check("perr_71", 32'(perr_obs), 32'd0);
      idle(2);
    end

    // Randomized traffic
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) zeros($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      clr_req = ($urandom_range(0, 7) == 0);
      send_frame(W'($urandom), 1'($urandom_range(0, 1)), 1'b1, -1);
      clr_req = 1'b0;
    end
    rdy_mode = 1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
